ttt_game_ctrl: RTL

//  Tic-tac-toe game sequencer. Owns the 18-bit board register driven into the dot-matrix display.

---
 rtl/ttt_pkg.sv | 50 +++++
 rtl/ttt_line_check.sv | 23 ++
 rtl/ttt_game_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/ttt_pkg.sv
// Shared types, encodings and board helpers for the tic-tac-toe controller.
package ttt_pkg;

  localparam int unsigned CELL_W  = 2;
  localparam int unsigned NCELLS  = 9;
  localparam int unsigned BOARD_W = NCELLS * CELL_W;
  localparam int unsigned CODE_W  = 4;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned NLINES  = 8;

  // Cell / player encodings (3 is never driven)
  localparam logic [CELL_W-1:0] EMPTY = 2'd0;
  localparam logic [CELL_W-1:0] PX    = 2'd1;
  localparam logic [CELL_W-1:0] PO    = 2'd2;

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_PLACE = 2'd1,
    ST_CHECK = 2'd2,
    ST_OVER  = 2'd3
  } state_e;

  // Winning lines, one cell index (1..9) per nibble: rows, columns, diagonals
  localparam logic [NLINES-1:0][11:0] WIN_LINES = {
    12'h123, 12'h456, 12'h789,
    12'h147, 12'h258, 12'h369,
    12'h159, 12'h357
  };

  // Bit offset of cell 'code' inside the board vector
  function automatic logic [4:0] cell_lsb(input logic [CODE_W-1:0] code);
    return 5'((5'(code) - 5'd1) << 1);
  endfunction

  // Contents of cell 'code'; out-of-range codes shift past the board and read EMPTY
  function automatic logic [CELL_W-1:0] cell_get(input logic [BOARD_W-1:0] b,
                                                 input logic [CODE_W-1:0]  code);
    return CELL_W'(b >> cell_lsb(code));
  endfunction

  // Key codes 1..9 address a cell; everything else is illegal
  function automatic logic code_legal(input logic [CODE_W-1:0] code);
    return (code != 4'd0) && (code <= 4'd9);
  endfunction

  function automatic logic [CELL_W-1:0] other_player(input logic [CELL_W-1:0] p);
    return (p == PX) ? PO : PX;
  endfunction

endpackage

// File: rtl/ttt_line_check.sv
// Combinational three-in-a-row detector for one player over the whole board.
module ttt_line_check
  import ttt_pkg::*;
(
  input  logic [BOARD_W-1:0] board_i,
  input  logic [CELL_W-1:0]  player_i,
  output logic               hit_c_o
);

  // Any of the eight lines fully owned by player_i; EMPTY never counts as an owner
  always_comb begin
    hit_c_o = 1'b0;
    for (int i = 0; i < int'(NLINES); i++) begin
      if ((player_i != EMPTY) &&
          (cell_get(board_i, WIN_LINES[i][11:8]) == player_i) &&
          (cell_get(board_i, WIN_LINES[i][7:4])  == player_i) &&
          (cell_get(board_i, WIN_LINES[i][3:0])  == player_i)) begin
        hit_c_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe sequencer: validates keypad moves, owns the display board, detects win/draw.
module ttt_game_ctrl
  import ttt_pkg::*;
#(
  parameter logic [1:0]  FIRST_PLAYER = 2'd1,
  parameter int unsigned TURN_TIMEOUT = 25_000_000
) (
  input  logic               freq,
  input  logic               rst,
  input  logic               key_valid,
  input  logic [CODE_W-1:0]  key_code,
  input  logic               new_game,
  output logic [BOARD_W-1:0] board,
  output logic [CELL_W-1:0]  cur_player,
  output logic [CELL_W-1:0]  winner,
  output logic               draw,
  output logic               game_over,
  output logic               err
);

  localparam int unsigned TMR_W = (TURN_TIMEOUT == 0) ? 1 : $clog2(TURN_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = (TURN_TIMEOUT == 0) ? '0 : TMR_W'(TURN_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NCELLS);

  state_e             state_q,  state_d;
  logic [BOARD_W-1:0] board_q,  board_d;
  logic [CELL_W-1:0]  cur_q,    cur_d;
  logic [CELL_W-1:0]  winner_q, winner_d;
  logic               draw_q,   draw_d;
  logic               over_q,   over_d;
  logic               err_q,    err_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [TMR_W-1:0]   timer_q,  timer_d;
  logic [CODE_W-1:0]  cell_q,   cell_d;

  logic               line_hit_c;
  logic               key_acc_c;

  // Win evaluation always looks at the committed board for the player who just moved
  ttt_line_check u_line_check (
    .board_i  (board_q),
    .player_i (cur_q),
    .hit_c_o  (line_hit_c)
  );

  // A key is takeable when it names a real cell that is still empty
  assign key_acc_c = key_valid && code_legal(key_code) && (cell_get(board_q, key_code) == EMPTY);

  // State and datapath registers with synchronous reset
  always_ff @(posedge freq) begin
    if (rst) begin
      state_q  <= ST_WAIT;
      board_q  <= '0;
      cur_q    <= FIRST_PLAYER;
      winner_q <= EMPTY;
      draw_q   <= 1'b0;
      over_q   <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      timer_q  <= '0;
      cell_q   <= '0;
    end else begin
      state_q  <= state_d;
      board_q  <= board_d;
      cur_q    <= cur_d;
      winner_q <= winner_d;
      draw_q   <= draw_d;
      over_q   <= over_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      timer_q  <= timer_d;
      cell_q   <= cell_d;
    end
  end

  // Next-state logic; new_game pre-empts everything, including a simultaneous key
  always_comb begin
    state_d  = state_q;
    board_d  = board_q;
    cur_d    = cur_q;
    winner_d = winner_q;
    draw_d   = draw_q;
    over_d   = over_q;
    err_d    = 1'b0;
    cnt_d    = cnt_q;
    timer_d  = timer_q;
    cell_d   = cell_q;

    if (new_game) begin
      state_d  = ST_WAIT;
      board_d  = '0;
      cur_d    = FIRST_PLAYER;
      winner_d = EMPTY;
      draw_d   = 1'b0;
      over_d   = 1'b0;
      cnt_d    = '0;
      timer_d  = '0;
    end else begin
      case (state_q)
        ST_WAIT: begin
          if (key_acc_c) begin
            // An accepted move takes precedence over a timeout expiring this cycle
            cell_d  = key_code;
            state_d = ST_PLACE;
          end else begin
            err_d = key_valid;
            if (TURN_TIMEOUT != 0) begin
              if (timer_q == TMR_LAST) begin
                cur_d   = other_player(cur_q);
                timer_d = '0;
              end else begin
                timer_d = timer_q + TMR_W'(1);
              end
            end
          end
        end
        ST_PLACE: begin
          err_d   = key_valid;
          board_d = board_q | (BOARD_W'(cur_q) << cell_lsb(cell_q));
          cnt_d   = (cnt_q == CNT_FULL) ? cnt_q : cnt_q + CNT_W'(1);
          timer_d = '0;
          state_d = ST_CHECK;
        end
        ST_CHECK: begin
          err_d = key_valid;
          if (line_hit_c) begin
            winner_d = cur_q;
            over_d   = 1'b1;
            cur_d    = EMPTY;
            state_d  = ST_OVER;
          end else if (cnt_q == CNT_FULL) begin
            draw_d  = 1'b1;
            over_d  = 1'b1;
            cur_d   = EMPTY;
            state_d = ST_OVER;
          end else begin
            cur_d   = other_player(cur_q);
            state_d = ST_WAIT;
          end
        end
        ST_OVER: begin
          err_d = key_valid;
        end
        default: begin
          state_d = ST_WAIT;
        end
      endcase
    end
  end

  assign board      = board_q;
  assign cur_player = cur_q;
  assign winner     = winner_q;
  assign draw       = draw_q;
  assign game_over  = over_q;
  assign err        = err_q;

endmodule
